// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, widths and lock FSM encoding.
// Used by both the display side and the capture side of the link.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_ACTIVE = 480;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = 525;

    localparam logic SYNC_POL = 1'b0;

    localparam int RGB_W       = 9;
    localparam int ADDR_W      = 19;
    localparam int CNT_W       = 10;
    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-stage sync register with polarity-normalised assertion edge.
// Ports: clk_i, rst_ni (async low), sync_i raw sync, edge_o pulse.
module sync_edge_detect #(
    parameter logic POL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;

    // Reset to the deasserted level so a stream that starts
    // inside sync still yields an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= ~POL;
            s2_q <= ~POL;
        end else begin
            s1_q <= sync_i;
            s2_q <= s1_q;
        end
    end

    assign edge_o = (s1_q == POL) && (s2_q != POL);

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers position, locks to timing, writes frames.
// In: clock, reset, vgaRGB, vgaHsync, vgaVsync, captureEn.
// Out: wrEn/wrAddr/wrData, pixelCnt, lineCnt, locked, frameDone, timingErr.
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int   HACT  = H_ACTIVE,
    parameter int   HSYNC = H_SYNC,
    parameter int   HBACK = H_BACK,
    parameter int   HTOT  = H_TOTAL,
    parameter int   VACT  = V_ACTIVE,
    parameter int   VSYNC = V_SYNC,
    parameter int   VBACK = V_BACK,
    parameter int   VTOT  = V_TOTAL,
    parameter logic POL   = SYNC_POL,
    parameter int   LOCKN = LOCK_FRAMES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RGB_W-1:0]  vgaRGB,
    input  logic              vgaHsync,
    input  logic              vgaVsync,
    input  logic              captureEn,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [RGB_W-1:0]  wrData,
    output logic [9:0]        pixelCnt,
    output logic [8:0]        lineCnt,
    output logic              locked,
    output logic              frameDone,
    output logic              timingErr
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t H_LAST  = cnt_t'(HTOT - 1);
    localparam cnt_t V_LAST  = cnt_t'(VTOT - 1);
    localparam cnt_t H_START = cnt_t'(HSYNC + HBACK);
    localparam cnt_t H_END   = cnt_t'(HSYNC + HBACK + HACT);
    localparam cnt_t V_START = cnt_t'(VSYNC + VBACK);
    localparam cnt_t V_END   = cnt_t'(VSYNC + VBACK + VACT);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(HACT * VACT - 1);
    localparam logic [3:0]        GOOD_LAST = 4'(LOCKN - 1);

    logic [RGB_W-1:0]  rgb_q;
    logic              hs_edge;
    logic              vs_edge;
    cnt_t              h_q;
    cnt_t              h_d;
    cnt_t              v_q;
    cnt_t              v_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        good_q;
    logic              arm_q;
    lock_state_e       state_q;

    logic act;
    logic mismatch;
    logic lose;
    logic wr;

    sync_edge_detect #(.POL(POL)) u_hs (
        .clk_i  (clock),
        .rst_ni (reset),
        .sync_i (vgaHsync),
        .edge_o (hs_edge)
    );

    sync_edge_detect #(.POL(POL)) u_vs (
        .clk_i  (clock),
        .rst_ni (reset),
        .sync_i (vgaVsync),
        .edge_o (vs_edge)
    );

    // h_d/v_d are the coordinates of the pixel now held in rgb_q.
    always_comb begin
        h_d = h_q;
        if (hs_edge) begin
            h_d = '0;
        end else if (h_q != CNT_MAX) begin
            h_d = h_q + CNT_ONE;
        end
    end

    // vsync reset wins over an hsync increment on the same clock.
    always_comb begin
        v_d = v_q;
        if (vs_edge) begin
            v_d = '0;
        end else if (hs_edge && v_q != CNT_MAX) begin
            v_d = v_q + CNT_ONE;
        end
    end

    assign act = (h_d >= H_START) && (h_d < H_END)
              && (v_d >= V_START) && (v_d < V_END);

    // No length checks while searching: the counters are not yet
    // referenced to a real frame start.
    assign mismatch = (state_q != ST_SEARCH)
                   && ((hs_edge && h_q != H_LAST)
                    || (vs_edge && v_q != V_LAST));

    assign lose = mismatch || (h_d == CNT_MAX);

    assign wr = arm_q && (state_q == ST_LOCKED) && !lose && act;

    always_comb begin
        addr_d = addr_q;
        if (vs_edge) begin
            addr_d = '0;
        end else if (wr) begin
            addr_d = addr_q + ADDR_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            good_q    <= '0;
            arm_q     <= 1'b0;
            state_q   <= ST_SEARCH;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            pixelCnt  <= '0;
            lineCnt   <= '0;
            locked    <= 1'b0;
            frameDone <= 1'b0;
            timingErr <= 1'b0;
        end else begin
            rgb_q     <= vgaRGB;
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            timingErr <= mismatch;
            wrEn      <= wr;
            frameDone <= wrEn && (wrAddr == ADDR_LAST);
            if (wr) begin
                wrAddr   <= addr_q;
                wrData   <= rgb_q;
                pixelCnt <= h_d - H_START;
                lineCnt  <= 9'(v_d - V_START);
            end
            unique case (state_q)
                ST_SEARCH: begin
                    if (vs_edge) begin
                        state_q <= ST_ALIGN;
                        good_q  <= '0;
                    end
                end
                ST_ALIGN: begin
                    if (lose) begin
                        state_q <= ST_SEARCH;
                    end else if (vs_edge) begin
                        if (good_q == GOOD_LAST) begin
                            state_q <= ST_LOCKED;
                            locked  <= 1'b1;
                            arm_q   <= captureEn;
                        end else begin
                            good_q <= good_q + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lose) begin
                        state_q <= ST_SEARCH;
                        locked  <= 1'b0;
                        arm_q   <= 1'b0;
                    end else if (vs_edge) begin
                        arm_q <= captureEn;
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                    locked  <= 1'b0;
                    arm_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced raster, active-low and
// active-high sync builds driven with the same stream.
module tb_vga_capture;

    localparam int HA = 8;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VT = 10;
    localparam int HS0 = HS + HB;
    localparam int VS0 = VS + VB;
    localparam int LAST = HA * VA - 1;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [8:0]  data;
        logic [9:0]  x;
        logic [8:0]  y;
    } exp_t;

    typedef struct {
        int gap;
        int cap;
        int short_ln;
        int drop_ln;
        int rst_ln;
        int exp_cap;
        int exp_lock;
        int exp_terr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] rgb = '0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       cap_en = 1'b0;

    logic        we_o  [2];
    logic [18:0] adr_o [2];
    logic [8:0]  dat_o [2];
    logic [9:0]  px_o  [2];
    logic [8:0]  ln_o  [2];
    logic        lk_o  [2];
    logic        fd_o  [2];
    logic        te_o  [2];

    int checks = 0;
    int failures = 0;
    int wcnt [2];
    int fdcnt [2];
    int tecnt [2];
    exp_t pipe [2];
    logic fd_due = 1'b0;
    vec_t tbl [15];

    always #5 clk = ~clk;

    vga_capture #(
        .HACT(HA), .HSYNC(HS), .HBACK(HB), .HTOT(HT),
        .VACT(VA), .VSYNC(VS), .VBACK(VB), .VTOT(VT),
        .POL(1'b0), .LOCKN(2)
    ) dut0 (
        .clock(clk), .reset(rst_n), .vgaRGB(rgb),
        .vgaHsync(~hs), .vgaVsync(~vs), .captureEn(cap_en),
        .wrEn(we_o[0]), .wrAddr(adr_o[0]), .wrData(dat_o[0]),
        .pixelCnt(px_o[0]), .lineCnt(ln_o[0]), .locked(lk_o[0]),
        .frameDone(fd_o[0]), .timingErr(te_o[0])
    );

    vga_capture #(
        .HACT(HA), .HSYNC(HS), .HBACK(HB), .HTOT(HT),
        .VACT(VA), .VSYNC(VS), .VBACK(VB), .VTOT(VT),
        .POL(1'b1), .LOCKN(2)
    ) dut1 (
        .clock(clk), .reset(rst_n), .vgaRGB(rgb),
        .vgaHsync(hs), .vgaVsync(vs), .captureEn(cap_en),
        .wrEn(we_o[1]), .wrAddr(adr_o[1]), .wrData(dat_o[1]),
        .pixelCnt(px_o[1]), .lineCnt(ln_o[1]), .locked(lk_o[1]),
        .frameDone(fd_o[1]), .timingErr(te_o[1])
    );

    function automatic logic [8:0] pat(input logic [9:0] x,
                                       input logic [9:0] y);
        return {x[2:0], y[2:0], x[5:3]};
    endfunction

    task automatic cmp(input string nm, input int d,
                       input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t",
                     nm, d, act, want, $time);
        end
    endtask

    task automatic zero_check(input int d);
        cmp("rst_wrEn", d, 32'(we_o[d]), 0);
        cmp("rst_wrAddr", d, 32'(adr_o[d]), 0);
        cmp("rst_wrData", d, 32'(dat_o[d]), 0);
        cmp("rst_pixelCnt", d, 32'(px_o[d]), 0);
        cmp("rst_lineCnt", d, 32'(ln_o[d]), 0);
        cmp("rst_locked", d, 32'(lk_o[d]), 0);
        cmp("rst_frameDone", d, 32'(fd_o[d]), 0);
        cmp("rst_timingErr", d, 32'(te_o[d]), 0);
    endtask

    task automatic check_out(input int d, input exp_t e);
        cmp("wrEn", d, 32'(we_o[d]), 32'(e.we));
        cmp("frameDone", d, 32'(fd_o[d]), 32'(fd_due));
        if (e.we) begin
            cmp("wrAddr", d, 32'(adr_o[d]), 32'(e.addr));
            cmp("wrData", d, 32'(dat_o[d]), 32'(e.data));
            cmp("pixelCnt", d, 32'(px_o[d]), 32'(e.x));
            cmp("lineCnt", d, 32'(ln_o[d]), 32'(e.y));
        end
        if (we_o[d]) wcnt[d]++;
        if (fd_o[d]) fdcnt[d]++;
        if (te_o[d]) tecnt[d]++;
    endtask

    task automatic step(input logic h, input logic v,
                        input logic [8:0] px, input exp_t e);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_out(d, pipe[1]);
        fd_due = pipe[1].we && (pipe[1].addr == 19'(LAST));
        pipe[1] = pipe[0];
        pipe[0] = e;
        hs = h;
        vs = v;
        rgb = px;
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 2; i++) begin
            pipe[i].we = 1'b0;
            pipe[i].addr = '0;
            pipe[i].data = '0;
            pipe[i].x = '0;
            pipe[i].y = '0;
        end
        fd_due = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) zero_check(d);
        clear_pipe();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t r);
        exp_t e;
        logic [8:0] px;
        bit act;
        int len;
        int ew;
        for (int d = 0; d < 2; d++) begin
            wcnt[d] = 0;
            fdcnt[d] = 0;
            tecnt[d] = 0;
        end
        e.we = 1'b0;
        e.addr = '0;
        e.data = '0;
        e.x = '0;
        e.y = '0;
        if (r.gap > 0) begin
            for (int i = 0; i < r.gap; i++) begin
                e.data = 9'($urandom);
                step(1'b0, 1'b0, e.data, e);
            end
        end else begin
            cap_en = r.cap[0];
            for (int y = 0; y < VT; y++) begin
                len = (y == r.short_ln) ? HT - 1 : HT;
                if (y == r.drop_ln) cap_en = 1'b0;
                for (int x = 0; x < len; x++) begin
                    act = x >= HS0 && x < HS0 + HA
                       && y >= VS0 && y < VS0 + VA;
                    px = act ? pat(10'(x - HS0), 10'(y - VS0))
                             : 9'($urandom);
                    e.we = r.exp_cap != 0 && act
                        && (r.short_ln < 0 || y <= r.short_ln);
                    e.addr = 19'((y - VS0) * HA + (x - HS0));
                    e.data = px;
                    e.x = 10'(x - HS0);
                    e.y = 9'(y - VS0);
                    step(x < HS, y < VS, px, e);
                    if (y == r.rst_ln && x == HS0 + 3) begin
                        do_reset();
                        return;
                    end
                end
            end
        end
        if (r.exp_cap == 0) ew = 0;
        else if (r.short_ln < 0) ew = HA * VA;
        else ew = (r.short_ln - VS0 + 1) * HA;
        for (int d = 0; d < 2; d++) begin
            cmp("frame_writes", d, 32'(wcnt[d]), 32'(ew));
            cmp("frame_done_cnt", d, 32'(fdcnt[d]),
                (r.exp_cap != 0 && r.short_ln < 0) ? 1 : 0);
            cmp("frame_terr_cnt", d, 32'(tecnt[d]), 32'(r.exp_terr));
            cmp("frame_locked", d, 32'(lk_o[d]), 32'(r.exp_lock));
        end
    endtask

    initial begin
        // gap cap short drop rst exp_cap exp_lock exp_terr
        tbl[0]  = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[1]  = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[2]  = '{0, 1, -1, -1, -1, 1, 1, 0};
        tbl[3]  = '{0, 1,  4, -1, -1, 1, 0, 1};
        tbl[4]  = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[5]  = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[6]  = '{0, 1, -1, -1, -1, 1, 1, 0};
        tbl[7]  = '{0, 1, -1,  5, -1, 1, 1, 0};
        tbl[8]  = '{0, 0, -1, -1, -1, 0, 1, 0};
        tbl[9]  = '{0, 1, -1, -1, -1, 1, 1, 0};
        tbl[10] = '{1100, 0, -1, -1, -1, 0, 0, 0};
        tbl[11] = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[12] = '{0, 1, -1, -1, -1, 0, 0, 0};
        tbl[13] = '{0, 1, -1, -1,  4, 1, 0, 0};
        tbl[14] = '{0, 1, -1, -1, -1, 0, 0, 0};

        clear_pipe();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) zero_check(d);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
